latch_hold_bank: RTL and testbench
==================================

# latch_hold_bank

Multi-channel, parametrised capture-and-hold bank: the synchronous, flop-based successor to the single hand-written `always_latch` holding register. Each of NUM_CH independent channels:
- opens a transparent window of OPEN_CYCLES cycles, during which its output follows its input;
- then freezes that value until released or, optionally, until a hold timeout expires.

It sits between asynchronous-ish status sources and the register/readback logic that needs stable snapshots.

## Interface
- NUM_CH, 4, number of independent channels (≥1)
- WIDTH, 8, data bits per channel (≥1)
- OPEN_CYCLES, 2, transparent window length in cycles (≥1)
- HOLD_CYCLES, 16, hold timeout in cycles (≥1; used only with timeout compiled in)
- i_clk  input  1  single clock; all state updates on rising edge
- i_arst_n  input  1  reset, asynchronous assert, active-low
- i_open  input  NUM_CH  per-channel request to open window
- i_release  input  NUM_CH  per-channel close/release
- i_data  input  NUM_CH*WIDTH  channel c data at bits [c*WIDTH +: WIDTH]
- o_ready  output  NUM_CH  channel in EMPTY, will accept i_open
- o_held  output  NUM_CH  channel in HELD
- o_expired  output  NUM_CH  one-cycle pulse on hold timeout
- o_data  output  NUM_CH*WIDTH  registered channel output, same packing as i_data

## Operation
- Per-channel FSM with states EMPTY, OPEN and HELD, and a down-counter CNT. Channels are fully independent.
- Reset values:
  - state EMPTY, CNT 0;
  - o_data 0, o_ready all 1, o_held 0, o_expired 0.
- EMPTY:
  - o_data keeps its last value.
  - i_open=1 → OPEN, CNT ← OPEN_CYCLES-1.
  - i_release is ignored.
- OPEN:
  - Every edge: o_data ← i_data (transparent, one-cycle registered).
  - i_release=1 → HELD (early close; that edge's capture still happens).
  - Otherwise, CNT==0 → HELD; else CNT decrements.
  - i_open is ignored.
- Entering HELD loads CNT ← HOLD_CYCLES-1.
- HELD:
  - o_data is frozen.
  - i_release=1 → EMPTY.
  - Otherwise, with timeout enabled, CNT==0 → EMPTY with o_expired=1 for exactly that following cycle; else CNT decrements.
  - i_open is ignored.
- Simultaneous release and timeout in HELD: release wins, no o_expired pulse.
- o_ready, o_held and o_expired are registered, decoded from the state and a registered pulse flag; no combinational input-to-output path.
- CNT width is $clog2(max(OPEN_CYCLES,HOLD_CYCLES)+1).
- Reset asserted mid-window or mid-hold: immediate return to reset values, no pulse.

## Timing
- i_open sampled at edge E0 → o_ready falls after E0.
- The first capture (of i_data present before E1) is visible after E1.
- Without early release, OPEN spans edges E1..E(OPEN_CYCLES); o_held rises after E(OPEN_CYCLES).
- Timeout: HELD entered after edge H; return to EMPTY and o_expired=1 occur after edge H+HOLD_CYCLES. o_ready rises in the same cycle.
- Release in HELD at edge R → EMPTY (o_ready=1) after R.
- Back-to-back reuse: i_open is accepted on the first edge where o_ready is already 1.

## Configuration
- Macro LATCH_HOLD_BANK_TIMEOUT_EN.
- Defined: the HELD down-counter, the timeout transition and o_expired are present.
- Undefined:
  - HELD is left only via i_release;
  - HOLD_CYCLES is unused;
  - o_expired is tied 0;
  - CNT is sized from OPEN_CYCLES only.

## Structure
- Package latch_hold_pkg holds:
  - the state enum (EMPTY, OPEN, HELD) as typedef lh_state_t;
  - a function computing the counter width from the parameters.
- Sub-module latch_hold_channel: one channel's FSM, counter and data register, parametrised by WIDTH/OPEN_CYCLES/HOLD_CYCLES.
- The top level generates NUM_CH instances and does the bus packing.

## Test plan
- Reset: hold i_arst_n=0 with random inputs → o_data=0, o_ready=4'b1111, o_held=0, o_expired=0.
- Open ch0 (defaults) with i_data ch0 = 0x11 then 0x22 then 0x33 on successive cycles → o_data ch0 shows 0x11 then 0x22, then holds 0x22. o_held[0] rises two edges after acceptance; 0x33 is never seen.
- Early close: open ch1, assert i_release on the first OPEN edge with data 0xA5 → o_held[1]=1 with o_data ch1=0xA5 after that edge.
- Timeout (macro defined): hold ch2 → after 16 edges in HELD, o_expired[2] pulses for one cycle and o_ready[2]=1. Release on the timeout edge → no pulse.
- Macro undefined: ch2 stays HELD for 100 cycles; i_release returns it to EMPTY; o_expired stays 0.
- Independence and reset mid-hold: open all four channels staggered by one cycle with distinct data → each holds its own value. Asserting i_arst_n mid-hold clears all channels immediately.

Source files
------------

// File: rtl/latch_hold_pkg.sv
// Shared types and helpers for the latch_hold_bank capture-and-hold bank.
// The optional hold timeout is selected with LATCH_HOLD_BANK_TIMEOUT_EN.
package latch_hold_pkg;

    // Per-channel state: waiting for a request, transparent window, frozen snapshot.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OPEN  = 2'd1,
        HELD  = 2'd2
    } lh_state_t;

    // Width of the shared down-counter. It only needs to span the hold
    // timeout when that timeout is actually compiled in.
    function automatic int lh_cnt_width(input int open_cycles,
                                        input int hold_cycles,
                                        input bit timeout_en);
        int span;
        span = open_cycles;
        if (timeout_en && (hold_cycles > open_cycles)) begin
            span = hold_cycles;
        end else begin
            span = open_cycles;
        end
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/latch_hold_channel.sv
// One capture-and-hold channel: EMPTY/OPEN/HELD FSM, shared down-counter and
// data register. All outputs are registered. Hold timeout is present only
// when LATCH_HOLD_BANK_TIMEOUT_EN is defined.
module latch_hold_channel
    import latch_hold_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int OPEN_CYCLES = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_open,
    input  logic             i_release,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_held,
    output logic             o_expired,
    output logic [WIDTH-1:0] o_data
);

`ifdef LATCH_HOLD_BANK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int CNT_W = lh_cnt_width(OPEN_CYCLES, HOLD_CYCLES, TIMEOUT_EN);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] OPEN_LOAD = CNT_W'(OPEN_CYCLES - 1);
`ifdef LATCH_HOLD_BANK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
`else
    // Without a timeout the counter is idle in HELD.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_ZERO;
`endif

    lh_state_t        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             ready_r;
    logic             held_r;
`ifdef LATCH_HOLD_BANK_TIMEOUT_EN
    logic             expired_r, expired_s;
`endif

    // Next-state, counter and capture decode for one channel.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        data_s  = data_r;
`ifdef LATCH_HOLD_BANK_TIMEOUT_EN
        expired_s = 1'b0;
`endif
        case (state_r)
            EMPTY: begin
                if (i_open) begin
                    state_s = OPEN;
                    cnt_s   = OPEN_LOAD;
                end else begin
                    state_s = EMPTY;
                end
            end
            OPEN: begin
                // The capture happens on every OPEN edge, including the
                // edge that closes the window early.
                data_s = i_data;
                if (i_release || (cnt_r == CNT_ZERO)) begin
                    state_s = HELD;
                    cnt_s   = HOLD_LOAD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            HELD: begin
                if (i_release) begin
                    // Release has priority over a coincident timeout.
                    state_s = EMPTY;
                    cnt_s   = CNT_ZERO;
                end else begin
`ifdef LATCH_HOLD_BANK_TIMEOUT_EN
                    if (cnt_r == CNT_ZERO) begin
                        state_s   = EMPTY;
                        cnt_s     = CNT_ZERO;
                        expired_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
`else
                    state_s = HELD;
`endif
                end
            end
            default: begin
                state_s = EMPTY;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, data and decoded status flags.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_r <= EMPTY;
            cnt_r   <= CNT_ZERO;
            data_r  <= {WIDTH{1'b0}};
            ready_r <= 1'b1;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            ready_r <= (state_s == EMPTY);
            held_r  <= (state_s == HELD);
        end
    end

`ifdef LATCH_HOLD_BANK_TIMEOUT_EN
    // One-cycle timeout pulse, registered alongside the state.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            expired_r <= 1'b0;
        end else begin
            expired_r <= expired_s;
        end
    end

    assign o_expired = expired_r;
`else
    assign o_expired = 1'b0;
`endif

    assign o_ready = ready_r;
    assign o_held  = held_r;
    assign o_data  = data_r;

endmodule

// File: rtl/latch_hold_bank.sv
// latch_hold_bank: NUM_CH independent capture-and-hold channels with packed
// data buses. Hold timeout is compiled in with LATCH_HOLD_BANK_TIMEOUT_EN.
module latch_hold_bank
    import latch_hold_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 8,
    parameter int OPEN_CYCLES = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic [NUM_CH-1:0]       i_open,
    input  logic [NUM_CH-1:0]       i_release,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]       o_ready,
    output logic [NUM_CH-1:0]       o_held,
    output logic [NUM_CH-1:0]       o_expired,
    output logic [NUM_CH*WIDTH-1:0] o_data
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        latch_hold_channel #(
            .WIDTH       (WIDTH),
            .OPEN_CYCLES (OPEN_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_ch (
            .i_clk     (i_clk),
            .i_arst_n  (i_arst_n),
            .i_open    (i_open[c]),
            .i_release (i_release[c]),
            .i_data    (i_data[c*WIDTH +: WIDTH]),
            .o_ready   (o_ready[c]),
            .o_held    (o_held[c]),
            .o_expired (o_expired[c]),
            .o_data    (o_data[c*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_latch_hold_bank.sv
// Directed self-checking bench for latch_hold_bank (default parameters).
// Timeout expectations follow LATCH_HOLD_BANK_TIMEOUT_EN.
module tb_latch_hold_bank;

    logic        clk;
    logic        arst_n;
    logic [3:0]  open_v;
    logic [3:0]  rel_v;
    logic [31:0] din;
    logic [3:0]  ready;
    logic [3:0]  held;
    logic [3:0]  expired;
    logic [31:0] dout;

    int n_cmp;
    int n_err;

    latch_hold_bank #(
        .NUM_CH      (4),
        .WIDTH       (8),
        .OPEN_CYCLES (2),
        .HOLD_CYCLES (16)
    ) dut (
        .i_clk     (clk),
        .i_arst_n  (arst_n),
        .i_open    (open_v),
        .i_release (rel_v),
        .i_data    (din),
        .o_ready   (ready),
        .o_held    (held),
        .o_expired (expired),
        .o_data    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        arst_n = 1'b0;
        open_v = 4'($urandom);
        rel_v  = 4'($urandom);
        din    = 32'($urandom);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            open_v = 4'($urandom);
            rel_v  = 4'($urandom);
            din    = 32'($urandom);
        end
        chk("rst_data", dout, 32'h0000_0000);
        chk("rst_ready", {28'd0, ready}, 32'h0000_000F);
        chk("rst_held", {28'd0, held}, 32'h0000_0000);
        chk("rst_expired", {28'd0, expired}, 32'h0000_0000);
        arst_n = 1'b1;
        open_v = 4'b0000;
        rel_v  = 4'b0000;
        din    = 32'h0000_0000;
        tick();

        // ch0 full window: 0x11, 0x22 captured, 0x33 never seen
        open_v    = 4'b0001;
        din[7:0]  = 8'h11;
        tick();                                 // E0: accepted
        open_v = 4'b0000;
        chk("ch0_ready_fall", {28'd0, ready}, 32'h0000_000E);
        chk("ch0_e0_data", dout, 32'h0000_0000);
        tick();                                 // E1: capture 0x11
        chk("ch0_e1_data", dout, 32'h0000_0011);
        chk("ch0_e1_held", {28'd0, held}, 32'h0000_0000);
        din[7:0] = 8'h22;
        tick();                                 // E2: capture 0x22, enter HELD
        chk("ch0_e2_data", dout, 32'h0000_0022);
        chk("ch0_e2_held", {28'd0, held}, 32'h0000_0001);
        din[7:0] = 8'h33;
        tick();
        chk("ch0_frozen", dout, 32'h0000_0022);
        chk("ch0_still_held", {28'd0, held}, 32'h0000_0001);
        rel_v = 4'b0001;
        tick();
        rel_v = 4'b0000;
        chk("ch0_release_ready", {28'd0, ready}, 32'h0000_000F);
        chk("ch0_release_held", {28'd0, held}, 32'h0000_0000);
        chk("ch0_release_keep", dout, 32'h0000_0022);

        // ch1 early close on the first OPEN edge
        open_v = 4'b0010;
        tick();
        open_v     = 4'b0000;
        din[15:8]  = 8'hA5;
        rel_v      = 4'b0010;
        tick();
        rel_v = 4'b0000;
        chk("ch1_early_held", {28'd0, held}, 32'h0000_0002);
        chk("ch1_early_data", dout, 32'h0000_A522);
        din[15:8] = 8'h5A;
        tick();
        chk("ch1_frozen", dout, 32'h0000_A522);
        rel_v = 4'b0010;
        tick();
        rel_v  = 4'b0000;
        chk("ch1_released", {28'd0, ready}, 32'h0000_000F);
        // Back-to-back reuse: ready already 1, so open is taken at once
        open_v = 4'b0010;
        tick();
        open_v = 4'b0000;
        chk("ch1_reopen", {28'd0, ready}, 32'h0000_000D);
        rel_v = 4'b0010;
        tick();                                 // early close, data 0x5A
        chk("ch1_reopen_data", dout, 32'h0000_5A22);
        tick();                                 // release in HELD
        rel_v = 4'b0000;
        chk("ch1_reopen_rel", {28'd0, ready}, 32'h0000_000F);

        // ch2 hold: timeout or indefinite hold
        open_v     = 4'b0100;
        din[23:16] = 8'h3C;
        tick();
        open_v = 4'b0000;
        tick();
        tick();                                 // edge H: HELD entered
        chk("ch2_held", {28'd0, held}, 32'h0000_0004);
        chk("ch2_data", dout, 32'h003C_5A22);
`ifdef LATCH_HOLD_BANK_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();   // H+15
        chk("ch2_pre_timeout_held", {28'd0, held}, 32'h0000_0004);
        chk("ch2_pre_timeout_exp", {28'd0, expired}, 32'h0000_0000);
        tick();                                 // H+16
        chk("ch2_timeout_exp", {28'd0, expired}, 32'h0000_0004);
        chk("ch2_timeout_ready", {28'd0, ready}, 32'h0000_000F);
        chk("ch2_timeout_held", {28'd0, held}, 32'h0000_0000);
        tick();
        chk("ch2_pulse_one_cycle", {28'd0, expired}, 32'h0000_0000);
        // Release coinciding with the timeout edge: no pulse
        open_v = 4'b0100;
        tick();
        open_v = 4'b0000;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        rel_v = 4'b0100;
        tick();
        rel_v = 4'b0000;
        chk("ch2_rel_wins_exp", {28'd0, expired}, 32'h0000_0000);
        chk("ch2_rel_wins_ready", {28'd0, ready}, 32'h0000_000F);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("ch2_long_held", {28'd0, held}, 32'h0000_0004);
        chk("ch2_long_exp", {28'd0, expired}, 32'h0000_0000);
        chk("ch2_long_data", dout, 32'h003C_5A22);
        rel_v = 4'b0100;
        tick();
        rel_v = 4'b0000;
        chk("ch2_rel_ready", {28'd0, ready}, 32'h0000_000F);
        chk("ch2_rel_exp", {28'd0, expired}, 32'h0000_0000);
`endif

        // Staggered opens on all channels, each with its own data
        din    = 32'h4332_2110;
        open_v = 4'b0001;
        tick();
        open_v = 4'b0010;
        tick();
        open_v = 4'b0100;
        tick();
        open_v = 4'b1000;
        tick();
        open_v = 4'b0000;
        tick();
        tick();
        chk("all_held", {28'd0, held}, 32'h0000_000F);
        chk("all_not_ready", {28'd0, ready}, 32'h0000_0000);
        din = 32'hFFFF_FFFF;
        tick();
        chk("all_data", dout, 32'h4332_2110);

        // Asynchronous reset mid-hold, mid-cycle
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_data", dout, 32'h0000_0000);
        chk("mid_rst_ready", {28'd0, ready}, 32'h0000_000F);
        chk("mid_rst_held", {28'd0, held}, 32'h0000_0000);
        chk("mid_rst_exp", {28'd0, expired}, 32'h0000_0000);
        tick();
        arst_n = 1'b1;
        tick();
        chk("post_rst_data", dout, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
